sevenseg_capture: RTL and testbench

- Receiving end of the board's multiplexed 7-segment interface.
- Samples the active-low anode, segment and dot lines, waits for each digit to settle, then decodes the segment pattern back to a BCD digit.
- Reassembles the two 2-digit fields into binary values.
- Used as an on-board self-check and bench monitor for the display path; it reverses the binary-to-BCD and segment-encode path.

---
 rtl/sevenseg_capture.sv | 233 +++++++++++++++++++++++
 tb/tb_sevenseg_capture.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sevenseg_capture.sv
// Receiving end of the multiplexed active-low 7-segment bus: waits for each digit
// to settle, decodes it back to BCD and rebuilds the two 2-digit binary fields.
module sevenseg_capture #(
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 1048576,
    parameter int CNT_W          = 21
) (
    input  logic       mclk,
    input  logic       rst_n,
    input  logic [3:0] an,
    input  logic [6:0] seg,
    input  logic       dp,
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic [3:0] digit3,
    output logic [3:0] dp_lit,
    output logic [7:0] value_lo,
    output logic [7:0] value_hi,
    output logic       frame_valid,
    output logic       seg_error,
    output logic       stale
);

    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
    localparam logic [CNT_W-1:0] SETTLE_LIM = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] TO_LIM     = CNT_W'(TIMEOUT_CYCLES);

    state_t           state_q, state_d;
    logic [3:0]       an_q, an_d, an_p_q, an_p_d;
    logic [6:0]       seg_q, seg_d, seg_p_q, seg_p_d;
    logic             dp_q, dp_d, dp_p_q, dp_p_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, to_cnt_q, to_cnt_d;
    logic [3:0][3:0]  shadow_q, shadow_d, digit_q, digit_d;
    logic [3:0]       shadow_dp_q, shadow_dp_d, dp_lit_q, dp_lit_d;
    logic [3:0]       seen_q, seen_d;
    logic [7:0]       value_lo_q, value_lo_d, value_hi_q, value_hi_d;
    logic             frame_valid_q, frame_valid_d;
    logic             seg_error_q, seg_error_d;
    logic             stale_q, stale_d;

    logic             changed, sel_valid, capture, frame_done;
    logic [1:0]       sel_idx;
    logic [3:0]       dec, seen_new;

    function automatic logic [3:0] decode_seg(input logic [6:0] pat);
        logic [3:0] d;
        case (pat)
            7'h3F:   d = 4'd0;
            7'h06:   d = 4'd1;
            7'h5B:   d = 4'd2;
            7'h4F:   d = 4'd3;
            7'h66:   d = 4'd4;
            7'h6D:   d = 4'd5;
            7'h7D:   d = 4'd6;
            7'h07:   d = 4'd7;
            7'h7F:   d = 4'd8;
            7'h6F:   d = 4'd9;
            7'h00:   d = 4'hF;
            default: d = 4'hE;
        endcase
        return d;
    endfunction

    // A blank tens digit is a suppressed leading zero; anything else non-numeric is unusable.
    function automatic logic [7:0] pair_value(input logic [3:0] tens, input logic [3:0] ones);
        logic [7:0] v;
        v = 8'hFF;
        if (ones <= 4'd9) begin
            if (tens <= 4'd9) begin
                v = {4'd0, tens} * 8'd10 + {4'd0, ones};
            end else if (tens == 4'hF) begin
                v = {4'd0, ones};
            end
        end
        return v;
    endfunction

    always_comb begin
        an_d          = an;
        seg_d         = seg;
        dp_d          = dp;
        an_p_d        = an_q;
        seg_p_d       = seg_q;
        dp_p_d        = dp_q;
        state_d       = state_q;
        cnt_d         = cnt_q;
        shadow_d      = shadow_q;
        shadow_dp_d   = shadow_dp_q;
        seen_d        = seen_q;
        seen_new      = seen_q;
        digit_d       = digit_q;
        dp_lit_d      = dp_lit_q;
        value_lo_d    = value_lo_q;
        value_hi_d    = value_hi_q;
        frame_valid_d = 1'b0;
        seg_error_d   = seg_error_q;
        to_cnt_d      = to_cnt_q;
        stale_d       = stale_q;
        capture       = 1'b0;
        frame_done    = 1'b0;

        changed = (an_q != an_p_q) || (seg_q != seg_p_q) || (dp_q != dp_p_q);

        sel_valid = 1'b1;
        sel_idx   = 2'd0;
        case (an_q)
            4'b1110: sel_idx = 2'd0;
            4'b1101: sel_idx = 2'd1;
            4'b1011: sel_idx = 2'd2;
            4'b0111: sel_idx = 2'd3;
            default: sel_valid = 1'b0;
        endcase

        dec = decode_seg(~seg_q);

        case (state_q)
            IDLE: begin
                if (sel_valid) begin
                    state_d = SETTLE;
                    cnt_d   = ONE;
                end
            end
            SETTLE: begin
                if (changed) begin
                    cnt_d   = ONE;
                    state_d = sel_valid ? SETTLE : IDLE;
                end else if (cnt_q + ONE >= SETTLE_LIM) begin
                    cnt_d   = SETTLE_LIM;
                    capture = 1'b1;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            HOLD: begin
                if (changed) begin
                    cnt_d   = ONE;
                    state_d = sel_valid ? SETTLE : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // The capture that fills the last seen slot publishes the whole frame at once.
        if (capture) begin
            shadow_d[sel_idx]    = dec;
            shadow_dp_d[sel_idx] = ~dp_q;
            seen_new[sel_idx]    = 1'b1;
            seen_d               = seen_new;
            if (dec == 4'hE) begin
                seg_error_d = 1'b1;
            end
            if (seen_new == 4'hF) begin
                frame_done    = 1'b1;
                seen_d        = 4'h0;
                digit_d       = shadow_d;
                dp_lit_d      = shadow_dp_d;
                value_lo_d    = pair_value(shadow_d[1], shadow_d[0]);
                value_hi_d    = pair_value(shadow_d[3], shadow_d[2]);
                frame_valid_d = 1'b1;
            end
        end

        if (frame_done) begin
            to_cnt_d = '0;
            stale_d  = 1'b0;
        end else if (to_cnt_q != TO_LIM) begin
            to_cnt_d = to_cnt_q + ONE;
            if (to_cnt_q + ONE == TO_LIM) begin
                stale_d = 1'b1;
            end
        end
    end

    always_ff @(posedge mclk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            an_q          <= 4'hF;
            seg_q         <= 7'h7F;
            dp_q          <= 1'b1;
            an_p_q        <= 4'hF;
            seg_p_q       <= 7'h7F;
            dp_p_q        <= 1'b1;
            cnt_q         <= '0;
            to_cnt_q      <= '0;
            shadow_q      <= {4{4'hF}};
            shadow_dp_q   <= 4'h0;
            seen_q        <= 4'h0;
            digit_q       <= {4{4'hF}};
            dp_lit_q      <= 4'h0;
            value_lo_q    <= 8'hFF;
            value_hi_q    <= 8'hFF;
            frame_valid_q <= 1'b0;
            seg_error_q   <= 1'b0;
            stale_q       <= 1'b1;
        end else begin
            state_q       <= state_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            an_p_q        <= an_p_d;
            seg_p_q       <= seg_p_d;
            dp_p_q        <= dp_p_d;
            cnt_q         <= cnt_d;
            to_cnt_q      <= to_cnt_d;
            shadow_q      <= shadow_d;
            shadow_dp_q   <= shadow_dp_d;
            seen_q        <= seen_d;
            digit_q       <= digit_d;
            dp_lit_q      <= dp_lit_d;
            value_lo_q    <= value_lo_d;
            value_hi_q    <= value_hi_d;
            frame_valid_q <= frame_valid_d;
            seg_error_q   <= seg_error_d;
            stale_q       <= stale_d;
        end
    end

    assign digit0      = digit_q[0];
    assign digit1      = digit_q[1];
    assign digit2      = digit_q[2];
    assign digit3      = digit_q[3];
    assign dp_lit      = dp_lit_q;
    assign value_lo    = value_lo_q;
    assign value_hi    = value_hi_q;
    assign frame_valid = frame_valid_q;
    assign seg_error   = seg_error_q;
    assign stale       = stale_q;

endmodule

// File: tb/tb_sevenseg_capture.sv
// Bench for sevenseg_capture: drives multiplexed scans and scoreboards the expected
// frame of each scan against frames seen on frame_valid.
module tb_sevenseg_capture;
    localparam int SETTLE  = 16;
    localparam int TIMEOUT = 3000;
    localparam int HOLDCYC = 64;

    localparam logic [6:0] P0 = 7'h3F, P1 = 7'h06, P2 = 7'h5B, P3 = 7'h4F, P4 = 7'h66;
    localparam logic [6:0] P6 = 7'h7D, P5 = 7'h6D, P7 = 7'h07, P8 = 7'h7F;
    localparam logic [6:0] PB = 7'h00, PX = 7'h12;

    typedef struct packed {
        logic [15:0] digits;
        logic [3:0]  dp_lit;
        logic [7:0]  vlo;
        logic [7:0]  vhi;
        logic        seg_error;
        logic        stale;
    } frame_t;

    logic       mclk = 1'b0;
    logic       rst_n;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] digit0, digit1, digit2, digit3, dp_lit;
    logic [7:0] value_lo, value_hi;
    logic       frame_valid, seg_error, stale;

    frame_t exp_q[$];
    frame_t obs_q[$];
    int     total = 0;
    int     bad = 0;
    int     pulses = 0;
    int     fv_cycles = 0;
    logic   fv_prev = 1'b0;
    logic   err_exp = 1'b0;

    sevenseg_capture #(
        .SETTLE_CYCLES (SETTLE),
        .TIMEOUT_CYCLES(TIMEOUT),
        .CNT_W         (21)
    ) dut (
        .mclk       (mclk),
        .rst_n      (rst_n),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .digit0     (digit0),
        .digit1     (digit1),
        .digit2     (digit2),
        .digit3     (digit3),
        .dp_lit     (dp_lit),
        .value_lo   (value_lo),
        .value_hi   (value_hi),
        .frame_valid(frame_valid),
        .seg_error  (seg_error),
        .stale      (stale)
    );

    always #5 mclk = ~mclk;

    // Frame monitor: records every published frame for the tests to pop.
    always @(negedge mclk) begin
        if (frame_valid === 1'b1) begin
            obs_q.push_back({digit3, digit2, digit1, digit0, dp_lit, value_lo, value_hi,
                             seg_error, stale});
            fv_cycles <= fv_cycles + 1;
            if (fv_prev !== 1'b1) pulses <= pulses + 1;
        end
        fv_prev <= frame_valid;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic frame_t mk(input logic [15:0] d, input logic [3:0] dl,
                                  input logic [7:0] lo, input logic [7:0] hi, input logic e);
        return {d, dl, lo, hi, e, 1'b0};
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(posedge mclk);
        #1;
    endtask

    // pats = {pos3, pos2, pos1, pos0} active-high patterns; dpm bit i lights dot i.
    task automatic scan(input logic [27:0] pats, input logic [3:0] dpm, input bit glitch);
        for (int i = 0; i < 4; i++) begin
            an  = ~(4'b0001 << i);
            seg = ~pats[i*7 +: 7];
            dp  = ~dpm[i];
            cycles(HOLDCYC);
            if (glitch && i < 3) begin
                seg = ~pats[(i+1)*7 +: 7];
                cycles(3);
            end
        end
        an  = 4'hF;
        seg = 7'h7F;
        dp  = 1'b1;
        cycles(4);
    endtask

    task automatic wait_frame(output frame_t got, output bit ok);
        int n;
        n  = 0;
        ok = 1'b0;
        got = '0;
        while (obs_q.size() == 0 && n < 200) begin
            @(posedge mclk);
            n++;
        end
        #1;
        if (obs_q.size() != 0) begin
            got = obs_q.pop_front();
            ok  = 1'b1;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        an    = 4'hF;
        seg   = 7'h7F;
        dp    = 1'b1;
        cycles(3);
        total++; if ({digit3, digit2, digit1, digit0} !== 16'hFFFF) begin bad++;
            $display("[TB] FAIL reset_digits: got=%h required=ffff", {digit3, digit2, digit1, digit0}); end
        total++; if (dp_lit !== 4'h0) begin bad++;
            $display("[TB] FAIL reset_dp_lit: got=%h required=0", dp_lit); end
        total++; if ({value_hi, value_lo} !== 16'hFFFF) begin bad++;
            $display("[TB] FAIL reset_values: got=%h required=ffff", {value_hi, value_lo}); end
        total++; if (frame_valid !== 1'b0) begin bad++;
            $display("[TB] FAIL reset_frame_valid: got=%b required=0", frame_valid); end
        total++; if (seg_error !== 1'b0) begin bad++;
            $display("[TB] FAIL reset_seg_error: got=%b required=0", seg_error); end
        total++; if (stale !== 1'b1) begin bad++;
            $display("[TB] FAIL reset_stale: got=%b required=1", stale); end
        rst_n = 1'b1;
        cycles(2);
    endtask

    task automatic test_basic;
        frame_t exp, got;
        bit ok;
        int p0, c0;
        p0 = pulses; c0 = fv_cycles;
        exp_q.push_back(mk(16'h2401, 4'h0, 8'd1, 8'd24, err_exp));
        scan({P2, P4, P0, P1}, 4'h0, 1'b0);
        wait_frame(got, ok);
        exp = exp_q.pop_front();
        total++; if (!ok || got !== exp) begin bad++;
            $display("[TB] FAIL basic_frame: got=%h seen=%0d required=%h", got, ok, exp); end
        total++; if (pulses - p0 != 1) begin bad++;
            $display("[TB] FAIL basic_pulses: got=%0d required=1", pulses - p0); end
        total++; if (fv_cycles - c0 != 1) begin bad++;
            $display("[TB] FAIL basic_pulse_width: got=%0d required=1", fv_cycles - c0); end
    endtask

    task automatic test_glitch;
        frame_t exp, got;
        bit ok;
        int p0;
        p0 = pulses;
        exp_q.push_back(mk(16'h2401, 4'h0, 8'd1, 8'd24, err_exp));
        scan({P2, P4, P0, P1}, 4'h0, 1'b1);
        wait_frame(got, ok);
        exp = exp_q.pop_front();
        total++; if (!ok || got !== exp) begin bad++;
            $display("[TB] FAIL glitch_frame: got=%h seen=%0d required=%h", got, ok, exp); end
        total++; if (pulses - p0 != 1) begin bad++;
            $display("[TB] FAIL glitch_pulses: got=%0d required=1", pulses - p0); end
    endtask

    task automatic test_dp;
        frame_t exp, got;
        bit ok;
        exp_q.push_back(mk(16'h2401, 4'b0101, 8'd1, 8'd24, err_exp));
        scan({P2, P4, P0, P1}, 4'b0101, 1'b0);
        wait_frame(got, ok);
        exp = exp_q.pop_front();
        total++; if (!ok || got !== exp) begin bad++;
            $display("[TB] FAIL dp_frame: got=%h seen=%0d required=%h", got, ok, exp); end
    endtask

    task automatic test_blank;
        frame_t exp, got;
        bit ok;
        exp_q.push_back(mk(16'h10F7, 4'h0, 8'd7, 8'd10, err_exp));
        scan({P1, P0, PB, P7}, 4'h0, 1'b0);
        wait_frame(got, ok);
        exp = exp_q.pop_front();
        total++; if (!ok || got !== exp) begin bad++;
            $display("[TB] FAIL blank_tens: got=%h seen=%0d required=%h", got, ok, exp); end
        exp_q.push_back(mk(16'hF52F, 4'h0, 8'hFF, 8'd5, err_exp));
        scan({PB, P5, P2, PB}, 4'h0, 1'b0);
        wait_frame(got, ok);
        exp = exp_q.pop_front();
        total++; if (!ok || got !== exp) begin bad++;
            $display("[TB] FAIL blank_ones: got=%h seen=%0d required=%h", got, ok, exp); end
    endtask

    task automatic test_illegal;
        frame_t exp, got;
        bit ok;
        err_exp = 1'b1;
        exp_q.push_back(mk(16'h8E63, 4'h0, 8'd63, 8'hFF, err_exp));
        scan({P8, PX, P6, P3}, 4'h0, 1'b0);
        wait_frame(got, ok);
        exp = exp_q.pop_front();
        total++; if (!ok || got !== exp) begin bad++;
            $display("[TB] FAIL illegal_frame: got=%h seen=%0d required=%h", got, ok, exp); end
        exp_q.push_back(mk(16'h2401, 4'h0, 8'd1, 8'd24, err_exp));
        scan({P2, P4, P0, P1}, 4'h0, 1'b0);
        wait_frame(got, ok);
        exp = exp_q.pop_front();
        total++; if (!ok || got !== exp) begin bad++;
            $display("[TB] FAIL illegal_sticky_frame: got=%h seen=%0d required=%h", got, ok, exp); end
        total++; if (seg_error !== 1'b1) begin bad++;
            $display("[TB] FAIL illegal_sticky: got=%b required=1", seg_error); end
    endtask

    task automatic test_timeout;
        frame_t exp, got;
        bit ok;
        an = 4'hF;
        cycles(100);
        total++; if (stale !== 1'b0) begin bad++;
            $display("[TB] FAIL timeout_early: got=%b required=0", stale); end
        cycles(TIMEOUT);
        total++; if (stale !== 1'b1) begin bad++;
            $display("[TB] FAIL timeout_stale: got=%b required=1", stale); end
        exp_q.push_back(mk(16'h2401, 4'h0, 8'd1, 8'd24, err_exp));
        scan({P2, P4, P0, P1}, 4'h0, 1'b0);
        wait_frame(got, ok);
        exp = exp_q.pop_front();
        total++; if (!ok || got !== exp) begin bad++;
            $display("[TB] FAIL timeout_recover: got=%h seen=%0d required=%h", got, ok, exp); end
    endtask

    task automatic test_reset_mid;
        frame_t exp, got;
        bit ok;
        int p0;
        logic [27:0] pats;
        pats = {P2, P4, P0, P1};
        for (int i = 0; i < 3; i++) begin
            an  = ~(4'b0001 << i);
            seg = ~pats[i*7 +: 7];
            dp  = 1'b1;
            cycles(HOLDCYC);
        end
        an = 4'hF;
        cycles(1);
        rst_n = 1'b0;
        cycles(1);
        rst_n = 1'b1;
        err_exp = 1'b0;
        total++; if ({digit3, digit2, digit1, digit0} !== 16'hFFFF) begin bad++;
            $display("[TB] FAIL midreset_digits: got=%h required=ffff", {digit3, digit2, digit1, digit0}); end
        total++; if (seg_error !== 1'b0 || stale !== 1'b1) begin bad++;
            $display("[TB] FAIL midreset_flags: got err=%b stale=%b required err=0 stale=1", seg_error, stale); end
        p0 = pulses;
        an  = 4'b0111;
        seg = ~P2;
        cycles(HOLDCYC);
        total++; if (pulses != p0 || {digit3, digit2, digit1, digit0} !== 16'hFFFF) begin bad++;
            $display("[TB] FAIL midreset_partial: got pulses=%0d digits=%h required pulses=0 digits=ffff",
                     pulses - p0, {digit3, digit2, digit1, digit0}); end
        exp_q.push_back(mk(16'h2401, 4'h0, 8'd1, 8'd24, err_exp));
        scan(pats, 4'h0, 1'b0);
        wait_frame(got, ok);
        exp = exp_q.pop_front();
        total++; if (!ok || got !== exp) begin bad++;
            $display("[TB] FAIL midreset_frame: got=%h seen=%0d required=%h", got, ok, exp); end
        total++; if (pulses - p0 != 1) begin bad++;
            $display("[TB] FAIL midreset_pulses: got=%0d required=1", pulses - p0); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_dp();
        test_blank();
        test_illegal();
        test_timeout();
        test_reset_mid();
        cycles(20);
        total++; if (obs_q.size() != 0) begin bad++;
            $display("[TB] FAIL extra_frames: got=%0d required=0", obs_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
